// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI3 widths, response/burst codes, FSM state encodings and address helpers
// for the SRAM responder.
package axi_sram_slave_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0]  AXI_RESP_DECERR = 2'b11;

  localparam logic [BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACC  = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Whole-burst check: WRAP and the reserved encoding are refused; otherwise the last
  // beat's word index must stay inside the window (addresses below base wrap to huge).
  function automatic logic [RESP_W-1:0] burst_resp(
    input logic [ADDR_W-1:0]  addr,
    input logic [LEN_W-1:0]   len,
    input logic [BURST_W-1:0] burst,
    input logic [ADDR_W-1:0]  base,
    input logic [31:0]        words
  );
    logic [ADDR_W:0] first_w;
    logic [ADDR_W:0] last_w;
    first_w = {1'b0, addr - base} >> 2;
    last_w  = first_w + ((burst == AXI_BURST_INCR) ? {{(ADDR_W-LEN_W+1){1'b0}}, len} : '0);
    if (burst == AXI_BURST_WRAP || burst == 2'b11)
      return AXI_RESP_SLVERR;
    else if (last_w >= {1'b0, words})
      return AXI_RESP_DECERR;
    else
      return AXI_RESP_OKAY;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0]  addr,
    input logic [BURST_W-1:0] burst
  );
    return (burst == AXI_BURST_INCR) ? addr + ADDR_W'(4) : addr;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between the core's initiator and the SRAM responder.
interface axi_sram_slave_if;
  import axi_sram_slave_pkg::*;

  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic [LOCK_W-1:0]  arlock;
  logic [CACHE_W-1:0] arcache;
  logic [PROT_W-1:0]  arprot;
  logic               arvalid;
  logic               arready;

  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic [LOCK_W-1:0]  awlock;
  logic [CACHE_W-1:0] awcache;
  logic [PROT_W-1:0]  awprot;
  logic               awvalid;
  logic               awready;

  logic [ID_W-1:0]    wid;
  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [ID_W-1:0]    bid;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_sram_slave_ram.sv
// Single-port synchronous SRAM, 32-bit words, byte write enables, one-cycle read latency.
module axi_sram_slave_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          wr,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // rdata only moves on a read access, so it holds across write cycles.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder in front of a single-port SRAM: independent read and write FSMs,
// per-burst range check, and a port arbiter where a write beat beats a pending read.
//
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR request
//   R_ACC  | issue the RAM read for the current beat (stalls while a write beat owns the port)
//   R_DATA | rvalid high, beat held until rready
//   W_IDLE | awready high, W held off
//   W_DATA | wready high, each beat writes the RAM in its own cycle
//   W_RESP | bvalid high until bready
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter int          MEM_WORDS = 4096,
  parameter bit          WSTRB_EN  = 1'b1
) (
  input  logic          aclk,
  input  logic          areset,
  axi_sram_slave_if.slave bus
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [ID_W-1:0]    r_id,    w_id;
  logic [ADDR_W-1:0]  r_addr,  w_addr;
  logic [LEN_W-1:0]   r_len,   w_len;
  logic [BURST_W-1:0] r_burst, w_burst;
  logic [RESP_W-1:0]  r_resp,  w_resp;
  logic [LEN_W-1:0]   r_cnt,   w_cnt;

  logic ar_hs, aw_hs, w_beat, w_wr, r_go, r_rd, r_fire, r_last, w_last_beat, wlast_bad;
  logic [ADDR_W-1:0] r_off, w_off;
  logic [31:0]       ram_rdata;

  assign ar_hs       = bus.arvalid && (r_state == R_IDLE) && !areset;
  assign aw_hs       = bus.awvalid && (w_state == W_IDLE) && !areset;
  assign w_beat      = bus.wvalid && (w_state == W_DATA) && !areset;
  assign w_wr        = w_beat && (w_resp == AXI_RESP_OKAY);
  // An error read needs no RAM access, so it never waits on the write port.
  assign r_go        = (r_state == R_ACC) && ((r_resp != AXI_RESP_OKAY) || !w_wr);
  assign r_rd        = r_go && (r_resp == AXI_RESP_OKAY);
  assign r_fire      = (r_state == R_DATA) && bus.rready;
  assign r_last      = (r_cnt == r_len);
  assign w_last_beat = (w_cnt == w_len);
  assign wlast_bad   = (w_len != '0) && (bus.wlast != w_last_beat);

  assign r_off = r_addr - BASE_ADDR;
  assign w_off = w_addr - BASE_ADDR;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next = r_state;
    w_next = w_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_ACC;
      R_ACC:   if (r_go) r_next = R_DATA;
      R_DATA:  if (bus.rready) r_next = r_last ? R_IDLE : R_ACC;
      default: r_next = R_IDLE;
    endcase
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_beat && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_burst <= '0; r_resp <= '0; r_cnt <= '0;
      w_id <= '0; w_addr <= '0; w_len <= '0; w_burst <= '0; w_resp <= '0; w_cnt <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= bus.arid;
        r_addr  <= bus.araddr;
        r_len   <= bus.arlen;
        r_burst <= bus.arburst;
        r_resp  <= burst_resp(bus.araddr, bus.arlen, bus.arburst, BASE_ADDR, MEM_WORDS_U);
        r_cnt   <= '0;
      end else if (r_fire && !r_last) begin
        r_cnt  <= r_cnt + LEN_W'(1);
        r_addr <= next_addr(r_addr, r_burst);
      end
      if (aw_hs) begin
        w_id    <= bus.awid;
        w_addr  <= bus.awaddr;
        w_len   <= bus.awlen;
        w_burst <= bus.awburst;
        w_resp  <= burst_resp(bus.awaddr, bus.awlen, bus.awburst, BASE_ADDR, MEM_WORDS_U);
        w_cnt   <= '0;
      end else if (w_beat) begin
        w_cnt  <= w_cnt + LEN_W'(1);
        w_addr <= next_addr(w_addr, w_burst);
        if (wlast_bad && w_resp == AXI_RESP_OKAY) w_resp <= AXI_RESP_SLVERR;
      end
    end
  end

  axi_sram_slave_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk   (aclk),
    .ce    (!areset && (w_wr || r_rd)),
    .wr    (w_wr),
    .be    (WSTRB_EN ? bus.wstrb : 4'hf),
    .addr  (w_wr ? w_off[AW+1:2] : r_off[AW+1:2]),
    .wdata (bus.wdata),
    .rdata (ram_rdata)
  );

  assign bus.arready = (r_state == R_IDLE) && !areset;
  assign bus.rvalid  = (r_state == R_DATA) && !areset;
  assign bus.rlast   = bus.rvalid && r_last;
  assign bus.rid     = r_id;
  assign bus.rresp   = r_resp;
  assign bus.rdata   = (bus.rvalid && r_resp == AXI_RESP_OKAY) ? ram_rdata : '0;
  assign bus.awready = (w_state == W_IDLE) && !areset;
  assign bus.wready  = (w_state == W_DATA) && !areset;
  assign bus.bvalid  = (w_state == W_RESP) && !areset;
  assign bus.bid     = w_id;
  assign bus.bresp   = w_resp;

  logic unused_bits;
  assign unused_bits = ^{bus.arsize, bus.arlock, bus.arcache, bus.arprot,
                         bus.awsize, bus.awlock, bus.awcache, bus.awprot,
                         bus.wid, r_off, w_off};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          WORDS = 4096;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [38:0] rq [$];
  logic [5:0]  bq [$];

  axi_sram_slave_if bus ();
  axi_sram_slave_if bus2 ();

  axi_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WSTRB_EN(1'b1)) dut (
    .aclk(aclk), .areset(areset), .bus(bus));
  axi_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WSTRB_EN(1'b0)) dut2 (
    .aclk(aclk), .areset(areset), .bus(bus2));

  assign bus2.arid = bus.arid;     assign bus2.araddr = bus.araddr;   assign bus2.arlen = bus.arlen;
  assign bus2.arsize = bus.arsize; assign bus2.arburst = bus.arburst; assign bus2.arlock = bus.arlock;
  assign bus2.arcache = bus.arcache; assign bus2.arprot = bus.arprot; assign bus2.arvalid = bus.arvalid;
  assign bus2.rready = bus.rready;
  assign bus2.awid = bus.awid;     assign bus2.awaddr = bus.awaddr;   assign bus2.awlen = bus.awlen;
  assign bus2.awsize = bus.awsize; assign bus2.awburst = bus.awburst; assign bus2.awlock = bus.awlock;
  assign bus2.awcache = bus.awcache; assign bus2.awprot = bus.awprot; assign bus2.awvalid = bus.awvalid;
  assign bus2.wid = bus.wid;       assign bus2.wdata = bus.wdata;     assign bus2.wstrb = bus.wstrb;
  assign bus2.wlast = bus.wlast;   assign bus2.wvalid = bus.wvalid;   assign bus2.bready = bus.bready;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Scoreboard monitor: R beats are compared every cycle they are shown (so a stalled
  // beat must hold), and popped on the handshake.
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.rvalid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=%0h required=none", bus.rdata);
        end else begin
          chk("r_beat", {25'd0, bus.rid, bus.rdata, bus.rresp, bus.rlast}, {25'd0, rq[0]});
          if (bus.rready) void'(rq.pop_front());
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=%0h required=none", {bus.bid, bus.bresp});
        end else begin
          chk("b_resp", {58'd0, bus.bid, bus.bresp}, {58'd0, bq[0]});
          void'(bq.pop_front());
        end
      end
    end
  end

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                    input logic [1:0] exp_resp, output int t_aw, output int t_w, output int t_b);
    int  beat;
    bit  aw_now, w_now;
    beat = 0; t_aw = -1; t_w = -1; t_b = -1;
    bq.push_back({id, exp_resp});
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    bus.wid = id; bus.wdata = data0; bus.wstrb = strb; bus.wlast = (len == 4'd0); bus.wvalid = 1'b1;
    for (int i = 0; i < 60 && t_b < 0; i++) begin
      @(negedge aclk);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      if (aw_now) t_aw = cyc;
      if (w_now && t_w < 0) t_w = cyc;
      if (bus.bvalid) t_b = cyc;
      @(posedge aclk); #1;
      if (aw_now) bus.awvalid = 1'b0;
      if (w_now) begin
        beat++;
        bus.wdata = data0 + 32'(beat);
        bus.wlast = (beat == int'(len));
        if (beat > int'(len)) bus.wvalid = 1'b0;
      end
    end
    if (t_b < 0) fail_timeout("write_burst");
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  // Returns at the negedge where the first rvalid is seen.
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, output int t_ar, output int t_rv);
    t_ar = -1; t_rv = -1;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.arready) begin t_ar = cyc; break; end
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    if (t_ar < 0) fail_timeout("ar_handshake");
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.rvalid) begin t_rv = cyc; break; end
    end
    if (t_rv < 0) fail_timeout("first_rvalid");
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
      @(posedge aclk); #1;
      n++;
      if (toggle) bus.rready = ~bus.rready;
    end
    if (n >= 100) fail_timeout("drain");
    bus.rready = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ta, tw, tb, tr, t0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = AXI_BURST_INCR;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = AXI_BURST_INCR;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ready_valid", {58'd0, bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast}, 64'd0);
    chk("rst_r_fields", {26'd0, bus.rdata, bus.rresp, bus.rid}, 64'd0);
    chk("rst_b_fields", {58'd0, bus.bid, bus.bresp}, 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("idle_ready", {61'd0, bus.arready, bus.awready, bus.wready}, 64'b110);
    @(posedge aclk); #1;

    // prefill words 0..9 with A5A5_000k
    wr(4'd1, BASE, 4'd9, AXI_BURST_INCR, 32'ha5a5_0000, 4'hf, AXI_RESP_OKAY, ta, tw, tb);
    drain(1'b0);

    // single read of word 2
    rq.push_back({4'd3, 32'ha5a5_0002, AXI_RESP_OKAY, 1'b1});
    rd(4'd3, BASE + 32'd8, 4'd0, AXI_BURST_INCR, ta, tr);
    chk("rd_latency", 64'(tr - ta), 64'd2);
    drain(1'b0);

    // AW+W together, low-half strobe
    wr(4'd5, BASE + 32'd4, 4'd0, AXI_BURST_INCR, 32'hdead_beef, 4'h3, AXI_RESP_OKAY, ta, tw, tb);
    chk("w_accept_latency", 64'(tw - ta), 64'd1);
    chk("b_latency", 64'(tb - ta), 64'd2);
    drain(1'b0);
    rq.push_back({4'd3, 32'ha5a5_beef, AXI_RESP_OKAY, 1'b1});
    rd(4'd3, BASE + 32'd4, 4'd0, AXI_BURST_INCR, ta, tr);
    drain(1'b0);

    // wstrb=0: ignored strobes on the second instance write the full word
    wr(4'd6, BASE + 32'd36, 4'd0, AXI_BURST_INCR, 32'h1234_5678, 4'h0, AXI_RESP_OKAY, ta, tw, tb);
    drain(1'b0);
    rq.push_back({4'd6, 32'ha5a5_0009, AXI_RESP_OKAY, 1'b1});
    rd(4'd6, BASE + 32'd36, 4'd0, AXI_BURST_INCR, ta, tr);
    chk("nostrb_rdata", {31'd0, bus2.rvalid, bus2.rdata}, {31'd0, 1'b1, 32'h1234_5678});
    drain(1'b0);

    // INCR x4 with rready toggling
    rq.push_back({4'd7, 32'ha5a5_0004, AXI_RESP_OKAY, 1'b0});
    rq.push_back({4'd7, 32'ha5a5_0005, AXI_RESP_OKAY, 1'b0});
    rq.push_back({4'd7, 32'ha5a5_0006, AXI_RESP_OKAY, 1'b0});
    rq.push_back({4'd7, 32'ha5a5_0007, AXI_RESP_OKAY, 1'b1});
    rd(4'd7, BASE + 32'd16, 4'd3, AXI_BURST_INCR, ta, tr);
    drain(1'b1);

    // FIXED x2 repeats word 3
    rq.push_back({4'd8, 32'ha5a5_0003, AXI_RESP_OKAY, 1'b0});
    rq.push_back({4'd8, 32'ha5a5_0003, AXI_RESP_OKAY, 1'b1});
    rd(4'd8, BASE + 32'd12, 4'd1, AXI_BURST_FIXED, ta, tr);
    drain(1'b0);

    // last word + 1 beat crosses the window top
    rq.push_back({4'd2, 32'h0, AXI_RESP_DECERR, 1'b0});
    rq.push_back({4'd2, 32'h0, AXI_RESP_DECERR, 1'b1});
    rd(4'd2, BASE + 32'(WORDS*4) - 32'd4, 4'd1, AXI_BURST_INCR, ta, tr);
    chk("err_rd_latency", 64'(tr - ta), 64'd2);
    drain(1'b0);

    rq.push_back({4'd5, 32'h0, AXI_RESP_DECERR, 1'b1});
    rd(4'd5, BASE - 32'd4, 4'd0, AXI_BURST_INCR, ta, tr);
    drain(1'b0);

    rq.push_back({4'd4, 32'h0, AXI_RESP_SLVERR, 1'b1});
    rd(4'd4, BASE + 32'd8, 4'd0, AXI_BURST_WRAP, ta, tr);
    drain(1'b0);

    // WRAP write refused, word 0 untouched
    wr(4'd1, BASE, 4'd0, AXI_BURST_WRAP, 32'hffff_ffff, 4'hf, AXI_RESP_SLVERR, ta, tw, tb);
    drain(1'b0);
    rq.push_back({4'd1, 32'ha5a5_0000, AXI_RESP_OKAY, 1'b1});
    rd(4'd1, BASE, 4'd0, AXI_BURST_INCR, ta, tr);
    drain(1'b0);

    // AR and AW in the same cycle to word 6: W beat collides with R_ACC
    rq.push_back({4'd9, 32'h0bad_cafe, AXI_RESP_OKAY, 1'b1});
    bq.push_back({4'd4, AXI_RESP_OKAY});
    bus.arid = 4'd9; bus.araddr = BASE + 32'd24; bus.arlen = 4'd0; bus.arburst = AXI_BURST_INCR; bus.arvalid = 1'b1;
    bus.awid = 4'd4; bus.awaddr = BASE + 32'd24; bus.awlen = 4'd0; bus.awburst = AXI_BURST_INCR; bus.awvalid = 1'b1;
    bus.wid = 4'd4; bus.wdata = 32'h0bad_cafe; bus.wstrb = 4'hf; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    @(negedge aclk);
    chk("conflict_ar_aw_ready", {62'd0, bus.arready, bus.awready}, 64'b11);
    t0 = cyc;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    @(negedge aclk);
    chk("conflict_wready", {63'd0, bus.wready}, 64'd1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    tr = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.rvalid) begin tr = cyc; break; end
    end
    if (tr < 0) fail_timeout("conflict_rvalid");
    chk("conflict_rd_latency", 64'(tr - t0), 64'd3);
    drain(1'b0);

    // reset while in W_DATA: burst dropped, no B, memory kept
    bus.awid = 4'd6; bus.awaddr = BASE + 32'd28; bus.awlen = 4'd3; bus.awburst = AXI_BURST_INCR; bus.awvalid = 1'b1;
    @(negedge aclk);
    chk("pre_rst_awready", {63'd0, bus.awready}, 64'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    @(negedge aclk);
    chk("w_data_wready", {63'd0, bus.wready}, 64'd1);
    @(posedge aclk); #1 areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_ready", {61'd0, bus.arready, bus.awready, bus.wready}, 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("post_rst_w", {61'd0, bus.awready, bus.wready, bus.bvalid}, 64'b100);
    end
    @(posedge aclk); #1;
    rq.push_back({4'd10, 32'h0bad_cafe, AXI_RESP_OKAY, 1'b1});
    rd(4'd10, BASE + 32'd24, 4'd0, AXI_BURST_INCR, ta, tr);
    drain(1'b0);
    rq.push_back({4'd11, 32'ha5a5_0007, AXI_RESP_OKAY, 1'b1});
    rd(4'd11, BASE + 32'd28, 4'd0, AXI_BURST_INCR, ta, tr);
    drain(1'b0);

    repeat (3) @(posedge aclk);
    chk("sb_empty", 64'(rq.size() + bq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
